// File: rtl/op2_div_seq.sv
// Sequential 8-bit unsigned restoring divider on 12-bit ALU buses.
// One op2 subtractor is reused for all eight iterations of a divide.

module op2 (
  input  logic [11:0] op_1,
  input  logic [11:0] op_2,
  output logic [11:0] result
);
  assign result = op_1 - op_2;
endmodule

module op2_div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] dividend,
  input  logic [11:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [11:0] quotient,
  output logic [11:0] remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_next;
  logic [7:0]  d_reg, q_reg, r_reg;
  logic [2:0]  cnt;
  logic [7:0]  rs, diff;
  logic [11:0] sub_result;
  logic        borrow, accept, zero_div;
  logic        unused_bits;

  assign accept   = start && (state != RUN);
  assign zero_div = (divisor[7:0] == 8'd0);

  // Shift the next dividend bit into the partial remainder, then trial-subtract.
  assign rs = {r_reg[6:0], q_reg[7]};

  op2 u_sub (
    .op_1   ({4'b0, rs}),
    .op_2   ({4'b0, d_reg}),
    .result (sub_result)
  );

  assign diff   = sub_result[7:0];
  assign borrow = (~rs[7] & d_reg[7]) | (~(rs[7] ^ d_reg[7]) & diff[7]);

  assign unused_bits = ^{sub_result[11:8], dividend[11:8], divisor[11:8]};

  // NOTE: state and data registers use non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = zero_div ? DONE : RUN;
      RUN:  if (cnt == 3'd7) state_next = DONE;
      DONE: begin
        if (start) state_next = zero_div ? DONE : RUN;
        else       state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_reg       <= 8'd0;
      q_reg       <= 8'd0;
      r_reg       <= 8'd0;
      cnt         <= 3'd0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      d_reg <= divisor[7:0];
      cnt   <= 3'd0;
      if (zero_div) begin
        q_reg       <= 8'hFF;
        r_reg       <= dividend[7:0];
        div_by_zero <= 1'b1;
      end else begin
        q_reg       <= dividend[7:0];
        r_reg       <= 8'd0;
        div_by_zero <= 1'b0;
      end
    end else if (state == RUN) begin
      r_reg <= borrow ? rs : diff;
      q_reg <= {q_reg[6:0], ~borrow};
      cnt   <= cnt + 3'd1;
    end
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign quotient  = {4'b0, q_reg};
  assign remainder = {4'b0, r_reg};

endmodule

// File: tb/tb_op2_div_seq.sv
// Scoreboard bench for op2_div_seq: drivers push expected results,
// an independent monitor pops and compares on every done pulse.

module tb_op2_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] dividend = 12'd0;
  logic [11:0] divisor = 12'd0;
  logic        busy, done, div_by_zero;
  logic [11:0] quotient, remainder;

  typedef struct {
    logic [11:0] q;
    logic [11:0] r;
    logic        z;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  op2_div_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%03h expected 0x%03h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    if (b == 8'd0) begin
      e.q = 12'h0FF; e.r = {4'b0, a}; e.z = 1'b1;
    end else begin
      e.q = {4'b0, a / b}; e.r = {4'b0, a % b}; e.z = 1'b0;
    end
    return e;
  endfunction

  function automatic exp_t mk(input logic [11:0] q, input logic [11:0] r, input logic z);
    exp_t e;
    e.q = q; e.r = r; e.z = z;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      check("busy_with_done", {11'b0, busy}, 12'h0);
      if (sb.size() == 0) begin
        check("unexpected_done", {11'b0, done}, 12'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_by_zero", {11'b0, div_by_zero}, {11'b0, e.z});
      end
    end
  end

  // Issue one divide with the given expectation and measure its latency.
  task automatic run_exp(input logic [11:0] a, input logic [11:0] b, input exp_t e, input int exp_busy);
    int nb;
    bit seen;
    sb.push_back(e);
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    nb = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
      else if (busy) nb++;
    end
    check("done_seen", {11'b0, seen}, 12'd1);
    check("busy_cycles", 12'(nb), 12'(exp_busy));
  endtask

  task automatic run_model(input logic [11:0] a, input logic [11:0] b);
    run_exp(a, b, model(a[7:0], b[7:0]), (b[7:0] == 8'd0) ? 0 : 8);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    bit seen;
    logic [7:0] bv [10];

    // Reset state
    #12;
    check("rst_quotient", quotient, 12'h000);
    check("rst_remainder", remainder, 12'h000);
    check("rst_busy", {11'b0, busy}, 12'h0);
    check("rst_done", {11'b0, done}, 12'h0);
    check("rst_dbz", {11'b0, div_by_zero}, 12'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors with hand-computed results
    run_exp(12'd200, 12'd7, mk(12'h01C, 12'h004, 1'b0), 8);
    repeat (3) @(negedge clk);
    check("held_quotient", quotient, 12'h01C);
    check("held_remainder", remainder, 12'h004);
    run_exp(12'd255, 12'd1,   mk(12'h0FF, 12'h000, 1'b0), 8);
    run_exp(12'd5,   12'd9,   mk(12'h000, 12'h005, 1'b0), 8);
    run_exp(12'd255, 12'd255, mk(12'h001, 12'h000, 1'b0), 8);
    run_exp(12'hF64, 12'hA03, mk(12'h021, 12'h001, 1'b0), 8);
    run_exp(12'h02A, 12'h000, mk(12'h0FF, 12'h02A, 1'b1), 0);
    run_exp(12'd10,  12'd3,   mk(12'h003, 12'h001, 1'b0), 8);
    run_exp(12'd128, 12'd128, mk(12'h001, 12'h000, 1'b0), 8);
    run_exp(12'd0,   12'd200, mk(12'h000, 12'h000, 1'b0), 8);

    // Start while busy is ignored; start held through DONE is accepted back-to-back
    sb.push_back(mk(12'h01C, 12'h004, 1'b0));
    @(negedge clk);
    dividend = 12'd200; divisor = 12'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    check("ign_busy", {11'b0, busy}, 12'h1);
    dividend = 12'd9; divisor = 12'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    sb.push_back(mk(12'h003, 12'h000, 1'b0));
    start = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("b2b_first_done", {11'b0, seen}, 12'd1);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("b2b_no_gap_busy", {11'b0, busy}, 12'h1);
    check("b2b_no_gap_done", {11'b0, done}, 12'h0);
    nb = 1; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
      else if (busy) nb++;
    end
    check("b2b_second_done", {11'b0, seen}, 12'd1);
    check("b2b_busy_cycles", 12'(nb), 12'd8);

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    dividend = 12'd200; divisor = 12'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_quotient", quotient, 12'h000);
    check("arst_remainder", remainder, 12'h000);
    check("arst_busy", {11'b0, busy}, 12'h0);
    check("arst_done", {11'b0, done}, 12'h0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("arst_no_done", {11'b0, seen}, 12'd0);
    run_exp(12'd100, 12'd10, mk(12'h00A, 12'h000, 1'b0), 8);

    // Reduced operand sweep against the reference model
    bv = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd7, 8'd16, 8'd127, 8'd128, 8'd200, 8'd255};
    for (int a = 0; a < 256; a += 17) begin
      for (int j = 0; j < 10; j++) begin
        run_model(12'(a), {4'b0, bv[j]});
      end
    end
    run_model(12'd255, 12'd254);
    run_model(12'd254, 12'd255);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 12'(sb.size()), 12'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
